// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and data-memory
// wait stalls for a 5-stage pipeline, plus a saturating count of PC-stalled cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [4:0]             id_rs1_i,
  input  logic [4:0]             id_rs2_i,
  input  logic [4:0]             ex_rd_i,
  input  logic                   ex_mem_rd_i,
  input  logic                   ex_branch_taken_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ready_i,
  input  logic                   stat_clr_i,
  output logic                   pc_en_o,
  output logic                   ifid_en_o,
  output logic                   idex_en_o,
  output logic                   exmem_en_o,
  output logic                   ifid_flush_o,
  output logic                   idex_flush_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    LOAD_BUBBLE = 2'b01,
    MEM_WAIT    = 2'b10,
    FLUSH       = 2'b11
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  state_t                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   memstall;
  logic                   loaduse;
  logic                   hold;

  assign memstall = mem_req_i & ~mem_ready_i;
  assign loaduse  = ex_mem_rd_i & (ex_rd_i != 5'd0) &
                    ((id_rs1_i == ex_rd_i) | (id_rs2_i == ex_rd_i));

  // MEM_WAIT holds on mem_ready_i alone; elsewhere a fresh memory stall holds.
  assign hold = (state_q == MEM_WAIT) ? ~mem_ready_i : memstall;

  // Next state and stage controls
  always_comb begin
    state_d      = state_q;
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    idex_en_o    = 1'b1;
    exmem_en_o   = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;

    if (!rst_n_i) begin
      state_d    = RUN;
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
    end else if (hold) begin
      state_d    = MEM_WAIT;
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (ex_branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_d      = FLUSH;
          end else if (loaduse) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
            state_d      = LOAD_BUBBLE;
          end else begin
            state_d = RUN;
          end
        end
        // ID/EX holds a bubble here, so hazards seen now are not real
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (stat_clr_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_en_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step queues its expected controls,
// state and counter, then pops and checks them on the following falling edge.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] OK = 6'b1111_00;  // {pc,ifid,idex,exmem,ifid_flush,idex_flush}
  localparam logic [5:0] ST = 6'b0000_00;
  localparam logic [5:0] BR = 6'b1111_11;
  localparam logic [5:0] LU = 6'b0011_01;

  typedef struct packed {
    logic [5:0] ef;
    logic [1:0] st;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_rd, ex_branch_taken, mem_req, mem_ready, stat_clr;
  logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
  logic [1:0] state;
  logic [3:0] stall_cnt;

  exp_t       sb_q[$];
  logic [3:0] exp_cnt = 4'd0;
  int         checks = 0;
  int         errors = 0;
  int         step_no = 0;

  pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_rd_i(ex_rd),
    .ex_mem_rd_i(ex_mem_rd), .ex_branch_taken_i(ex_branch_taken),
    .mem_req_i(mem_req), .mem_ready_i(mem_ready), .stat_clr_i(stat_clr),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en), .exmem_en_o(exmem_en),
    .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
    .state_o(state), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s step %0d: observed %b expected %b", tag, step_no, got, exp);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), check at the falling edge.
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic ld, input logic br,
                      input logic mreq, input logic mrdy, input logic clr,
                      input logic [5:0] ef, input logic [1:0] st);
    exp_t e;
    rst_n = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_mem_rd = ld; ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy; stat_clr = clr;
    if (!r) exp_cnt = 4'd0;
    e.ef = ef; e.st = st; e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (r) begin
      if (clr) exp_cnt = 4'd0;
      else if (!ef[5] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    end
    @(negedge clk);
    e = sb_q.pop_front();
    chk("ctl", {2'b00, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush},
        {2'b00, e.ef});
    chk("state", {6'b0, state}, {6'b0, e.st});
    chk("stall_cnt", {4'b0, stall_cnt}, {4'b0, e.cnt});
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // lu=1 presents a load-use pair on rs2 (rd=5, rs2=5); lu=0 has no dependency.
  task automatic s(input logic lu, input logic br, input logic mreq, input logic mrdy,
                   input logic clr, input logic [5:0] ef, input logic [1:0] st);
    step(1'b1, 5'd1, lu ? 5'd5 : 5'd2, 5'd5, lu, br, mreq, mrdy, clr, ef, st);
  endtask

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_rd = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    stat_clr = 1'b0;
    @(posedge clk); #1;
    // reset: everything off, also with a hazard and a branch on the inputs
    step(1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST, 2'd0);
    step(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ST, 2'd0);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // register 0 and non-matching loads never stall
    step(1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OK, 2'd0);
    step(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OK, 2'd0);
    // load-use on rs2, hazard held through the bubble
    s(1, 0, 0, 0, 0, LU, 2'd0);
    s(1, 0, 0, 0, 0, OK, 2'd1);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // load-use on rs1
    step(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU, 2'd0);
    s(0, 0, 0, 0, 0, OK, 2'd1);
    // three-cycle memory wait
    s(0, 0, 1, 0, 0, ST, 2'd0);
    s(0, 0, 1, 0, 0, ST, 2'd2);
    s(0, 0, 1, 0, 0, ST, 2'd2);
    s(0, 0, 1, 1, 0, OK, 2'd2);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // MEM_WAIT holds on mem_ready_i even when mem_req_i drops
    s(0, 0, 1, 0, 0, ST, 2'd0);
    s(0, 0, 0, 0, 0, ST, 2'd2);
    s(0, 0, 0, 1, 0, OK, 2'd2);
    // branch beats load-use; FLUSH ignores both
    s(1, 1, 0, 0, 0, BR, 2'd0);
    s(1, 1, 0, 0, 0, OK, 2'd3);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // memstall beats branch in RUN, then MEM_WAIT exit with branch
    s(1, 1, 1, 0, 0, ST, 2'd0);
    s(0, 1, 1, 1, 0, BR, 2'd2);
    s(0, 0, 0, 0, 0, OK, 2'd3);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // MEM_WAIT exit with load-use
    s(0, 0, 1, 0, 0, ST, 2'd0);
    s(1, 0, 1, 1, 0, LU, 2'd2);
    s(0, 0, 0, 0, 0, OK, 2'd1);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // memstall inside LOAD_BUBBLE and inside FLUSH
    s(1, 0, 0, 0, 0, LU, 2'd0);
    s(1, 1, 1, 0, 0, ST, 2'd1);
    s(0, 0, 1, 1, 0, OK, 2'd2);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    s(0, 1, 0, 0, 0, BR, 2'd0);
    s(1, 1, 1, 0, 0, ST, 2'd3);
    s(0, 0, 0, 1, 0, OK, 2'd2);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // counter: clear, then 20 stalled cycles saturate at 15
    s(0, 0, 0, 0, 1, OK, 2'd0);
    for (int i = 0; i < 20; i++) s(0, 0, 1, 0, 0, ST, (i == 0) ? 2'd0 : 2'd2);
    s(0, 0, 1, 1, 0, OK, 2'd2);
    s(0, 0, 0, 0, 1, OK, 2'd0);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // clear wins over increment
    s(0, 0, 1, 0, 1, ST, 2'd0);
    s(0, 0, 1, 0, 0, ST, 2'd2);
    s(0, 0, 1, 0, 0, ST, 2'd2);
    // reset mid-MEM_WAIT abandons the wait immediately
    step(1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ST, 2'd0);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    // reset mid-LOAD_BUBBLE and mid-FLUSH
    s(1, 0, 0, 0, 0, LU, 2'd0);
    step(1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST, 2'd0);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    s(0, 1, 0, 0, 0, BR, 2'd0);
    step(1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST, 2'd0);
    s(0, 0, 0, 0, 0, OK, 2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-002 The block SHALL have these ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- id_rs1_i  in  5  rs1 of the instruction in ID.
- id_rs2_i  in  5  rs2 of the instruction in ID.
- ex_rd_i  in  5  rd of the instruction in EX.
- ex_mem_rd_i  in  1  instruction in EX is a load.
- ex_branch_taken_i  in  1  branch/jump in EX resolved taken.
- mem_req_i  in  1  MEM stage is accessing data memory.
- mem_ready_i  in  1  data memory completes the access this cycle.
- stat_clr_i  in  1  synchronous clear of stall_cnt_o.
- pc_en_o  out  1  PC write enable.
- ifid_en_o  out  1  IF/ID register enable.
- idex_en_o  out  1  ID/EX register enable.
- exmem_en_o  out  1  EX/MEM and MEM/WB register enable.
- ifid_flush_o  out  1  IF/ID register loads a NOP.
- idex_flush_o  out  1  ID/EX register loads a NOP.
- state_o  out  2  current state encoding.
- stall_cnt_o  out  STALL_CNT_W  count of cycles with pc_en_o=0.

Function
REQ-003 The state machine SHALL have four states: RUN=00, LOAD_BUBBLE=01, MEM_WAIT=10, FLUSH=11. state_o SHALL equal the current state.
REQ-004 Outputs SHALL be combinational from the current state and current inputs; next state SHALL register on the rising edge of clk_i.
REQ-005 Terms: memstall = mem_req_i & ~mem_ready_i; loaduse = ex_mem_rd_i & (ex_rd_i!=0) & (id_rs1_i==ex_rd_i | id_rs2_i==ex_rd_i).
REQ-006 RUN evaluation, priority memstall > ex_branch_taken_i > loaduse:
- memstall: all four enables 0, flushes 0, next MEM_WAIT.
- ex_branch_taken_i: all enables 1, ifid_flush_o=1, idex_flush_o=1, next FLUSH.
- loaduse: pc_en_o=0, ifid_en_o=0, idex_en_o=1, exmem_en_o=1, idex_flush_o=1, ifid_flush_o=0, next LOAD_BUBBLE.
- none: all enables 1, flushes 0, stay RUN.
REQ-007 In MEM_WAIT with mem_ready_i=0, all enables SHALL be 0 and flushes 0, staying in MEM_WAIT indefinitely.
REQ-008 In MEM_WAIT with mem_ready_i=1, outputs and next state SHALL be exactly those of RUN evaluation, with memstall false.
REQ-009 In LOAD_BUBBLE, loaduse and ex_branch_taken_i SHALL be ignored. memstall SHALL act as in RUN. Otherwise all enables are 1, flushes 0, next RUN.
REQ-010 In FLUSH, loaduse and ex_branch_taken_i SHALL be ignored, since the instructions in ID/EX are bubbles. memstall SHALL act as in RUN. Otherwise all enables are 1, flushes 0, next RUN.
REQ-011 A load-use hazard SHALL insert exactly one bubble. A taken branch SHALL insert exactly two bubbles.
REQ-012 stall_cnt_o SHALL increment by 1 on each clock edge where pc_en_o=0, saturating at 2^STALL_CNT_W-1.
REQ-013 stat_clr_i=1 SHALL load stall_cnt_o with 0, taking priority over the increment.
REQ-014 Register index 0 SHALL never cause a load-use stall.

Reset
REQ-015 While rst_n_i=0: state SHALL be RUN, stall_cnt_o=0, all enables 0, flushes 0, independent of clk_i.
REQ-016 On the first clock edge after rst_n_i rises, the block SHALL evaluate from RUN with no residual stall.
REQ-017 Reset asserted mid-MEM_WAIT, LOAD_BUBBLE or FLUSH SHALL abandon that sequence immediately.

Verification
REQ-018 Load-use: ex_mem_rd_i=1, ex_rd_i=5, id_rs2_i=5 -> that cycle: pc_en_o=0, ifid_en_o=0, idex_flush_o=1. Next cycle: state_o=01, all enables 1. Following cycle: state_o=00. stall_cnt_o increments by 1.
REQ-019 ex_rd_i=0 with id_rs1_i=0 and ex_mem_rd_i=1 -> no stall, state stays 00.
REQ-020 Memory wait: mem_req_i=1, mem_ready_i=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, state_o=10, stall_cnt_o +3, return to 00.
REQ-021 Simultaneous branch and load-use in RUN -> both flushes 1, pc_en_o=1, next state 11, no LOAD_BUBBLE. Exit MEM_WAIT with ex_branch_taken_i=1 -> same flush, next state 11.
REQ-022 Counter: STALL_CNT_W=4 with 20 stalled cycles -> stall_cnt_o=15. stat_clr_i pulse -> 0. rst_n_i low mid-MEM_WAIT -> state_o=00 and stall_cnt_o=0 immediately.
